// File: rtl/cdma_req_sched_if.sv
// rtl/cdma_req_sched_if.sv - descriptor request and CDMA command bundle for cdma_req_sched
interface cdma_req_sched_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TRANS_WIDTH = 16,
    parameter int LEN_WIDTH   = 24
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_src;
    logic [ADDR_WIDTH-1:0]  req_dst;
    logic [LEN_WIDTH-1:0]   req_len;

    logic [ADDR_WIDTH-1:0]  cdma_src_addr;
    logic [ADDR_WIDTH-1:0]  cdma_dst_addr;
    logic [TRANS_WIDTH-1:0] cdma_trans_len;
    logic                   cdma_start;
    logic                   cdma_done;

    modport slave (
        input  req_valid, req_src, req_dst, req_len, cdma_done,
        output req_ready, cdma_src_addr, cdma_dst_addr, cdma_trans_len, cdma_start
    );

    modport master (
        output req_valid, req_src, req_dst, req_len, cdma_done,
        input  req_ready, cdma_src_addr, cdma_dst_addr, cdma_trans_len, cdma_start
    );
endinterface

// File: rtl/cdma_req_sched.sv
// rtl/cdma_req_sched.sv - queues copy descriptors and issues them to CDMA_Wrapper in chunks; CDMA_SCHED_4K_SPLIT_EN adds 4 KB boundary splitting
module cdma_req_sched #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TRANS_WIDTH = 16,
    parameter int LEN_WIDTH   = 24,
    parameter int MAX_CHUNK   = 4096,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    cdma_req_sched_if.slave   bus,
    output logic              busy,
    output logic              desc_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CALC  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    logic [ADDR_WIDTH-1:0] fifo_src_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_dst_q [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]  fifo_len_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  push;
    logic                  pop;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [TRANS_WIDTH-1:0] chunk_q, chunk_d;
    logic [ADDR_WIDTH-1:0] cdma_src_q, cdma_src_d;
    logic [ADDR_WIDTH-1:0] cdma_dst_q, cdma_dst_d;
    logic [TRANS_WIDTH-1:0] cdma_len_q, cdma_len_d;
    logic                  cdma_start_q, cdma_start_d;
    logic                  desc_done_q, desc_done_d;
    logic                  busy_q, busy_d;

    logic [LEN_WIDTH-1:0]  chunk_calc;

    assign full          = (count_q == CNT_W'(FIFO_DEPTH));
    assign push          = bus.req_valid && !full;
    assign pop           = (state_q == S_LOAD);
    assign bus.req_ready = !full;

    // Descriptor storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= bus.req_src;
            fifo_dst_q[wr_ptr_q] <= bus.req_dst;
            fifo_len_q[wr_ptr_q] <= bus.req_len;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Chunk size: remaining bytes capped by MAX_CHUNK, optionally by distance to the next 4 KB page.
`ifdef CDMA_SCHED_4K_SPLIT_EN
    logic [12:0]          src_page_room;
    logic [12:0]          dst_page_room;
    logic [LEN_WIDTH-1:0] chunk_cap;

    always_comb begin
        src_page_room = 13'h1000 - {1'b0, src_q[11:0]};
        dst_page_room = 13'h1000 - {1'b0, dst_q[11:0]};
        chunk_cap     = LEN_WIDTH'(MAX_CHUNK);
        if (LEN_WIDTH'(src_page_room) < chunk_cap) begin
            chunk_cap = LEN_WIDTH'(src_page_room);
        end
        if (LEN_WIDTH'(dst_page_room) < chunk_cap) begin
            chunk_cap = LEN_WIDTH'(dst_page_room);
        end
        chunk_calc = (rem_q < chunk_cap) ? rem_q : chunk_cap;
    end
`else
    always_comb begin
        chunk_calc = (rem_q < LEN_WIDTH'(MAX_CHUNK)) ? rem_q : LEN_WIDTH'(MAX_CHUNK);
    end
`endif

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        chunk_d    = chunk_q;
        cdma_src_d = cdma_src_q;
        cdma_dst_d = cdma_dst_q;
        cdma_len_d = cdma_len_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                src_d   = fifo_src_q[rd_ptr_q];
                dst_d   = fifo_dst_q[rd_ptr_q];
                rem_d   = fifo_len_q[rd_ptr_q];
                state_d = (fifo_len_q[rd_ptr_q] == '0) ? S_FIN : S_CALC;
            end
            S_CALC: begin
                chunk_d    = chunk_calc[TRANS_WIDTH-1:0];
                cdma_src_d = src_q;
                cdma_dst_d = dst_q;
                cdma_len_d = chunk_calc[TRANS_WIDTH-1:0];
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cdma_done) begin
                    src_d   = src_q + ADDR_WIDTH'(chunk_q);
                    dst_d   = dst_q + ADDR_WIDTH'(chunk_q);
                    rem_d   = rem_q - LEN_WIDTH'(chunk_q);
                    state_d = (rem_q == LEN_WIDTH'(chunk_q)) ? S_FIN : S_CALC;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulses and busy are registered from the next state so they line up with it.
        cdma_start_d = (state_d == S_ISSUE);
        desc_done_d  = (state_d == S_FIN);
        busy_d       = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            chunk_q      <= '0;
            cdma_src_q   <= '0;
            cdma_dst_q   <= '0;
            cdma_len_q   <= '0;
            cdma_start_q <= 1'b0;
            desc_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            chunk_q      <= chunk_d;
            cdma_src_q   <= cdma_src_d;
            cdma_dst_q   <= cdma_dst_d;
            cdma_len_q   <= cdma_len_d;
            cdma_start_q <= cdma_start_d;
            desc_done_q  <= desc_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cdma_src_addr  = cdma_src_q;
    assign bus.cdma_dst_addr  = cdma_dst_q;
    assign bus.cdma_trans_len = cdma_len_q;
    assign bus.cdma_start     = cdma_start_q;
    assign desc_done          = desc_done_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_cdma_req_sched.sv
// tb/tb_cdma_req_sched.sv - directed self-checking bench for cdma_req_sched
module tb_cdma_req_sched;
    localparam int AW = 32;
    localparam int TW = 16;
    localparam int LW = 24;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic desc_done;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    always #5 clk = ~clk;

    cdma_req_sched_if #(.ADDR_WIDTH(AW), .TRANS_WIDTH(TW), .LEN_WIDTH(LW)) bus ();

    cdma_req_sched #(
        .ADDR_WIDTH (AW),
        .TRANS_WIDTH(TW),
        .LEN_WIDTH  (LW),
        .MAX_CHUNK  (4096),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .desc_done(desc_done)
    );

    always @(negedge clk) begin
        if (bus.cdma_start === 1'b1) start_cnt <= start_cnt + 1;
        if (desc_done === 1'b1)      done_cnt  <= done_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.cdma_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [23:0] l);
        int n;
        @(negedge clk);
        bus.req_src   = s;
        bus.req_dst   = d;
        bus.req_len   = l;
        bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL push_timeout got=ready_low want=ready_high");
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.cdma_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(negedge clk);
        bus.cdma_done = 1'b1;
        @(negedge clk);
        bus.cdma_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.req_ready !== 1'b1 || bus.cdma_start !== 1'b0 || busy !== 1'b0 || desc_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=ready%b start%b busy%b done%b want=ready1 start0 busy0 done0",
                     bus.req_ready, bus.cdma_start, busy, desc_done);
        end
        total++;
        if (bus.cdma_src_addr !== 32'h0 || bus.cdma_dst_addr !== 32'h0 || bus.cdma_trans_len !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h want=0/0/0",
                     bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len);
        end
    endtask

    task automatic test_single();
        bit ok;
        int s0;
        int unstable;
        do_reset();
        s0 = start_cnt;
        push_desc(32'hC000_0000, 32'hC000_1000, 24'd64);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (bus.cdma_start !== (c == 4)) begin
                bad++;
                $display("FAIL single_latency cycle=k+%0d got=%b want=%b", c, bus.cdma_start, (c == 4));
            end
            if (c < 4) @(negedge clk);
        end
        total++;
        if (bus.cdma_src_addr !== 32'hC000_0000 || bus.cdma_dst_addr !== 32'hC000_1000 || bus.cdma_trans_len !== 16'd64) begin
            bad++;
            $display("FAIL single_cmd got=%h/%h/%0d want=c0000000/c0001000/64",
                     bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len);
        end
        unstable = 0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (bus.cdma_src_addr !== 32'hC000_0000 || bus.cdma_trans_len !== 16'd64 || bus.cdma_start !== 1'b0)
                unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL single_hold got=%0d_bad_cycles want=0", unstable);
        end
        pulse_done(0);
        total++;
        if (desc_done !== 1'b1) begin
            bad++;
            $display("FAIL single_desc_done got=%b want=1", desc_done);
        end
        @(negedge clk);
        total++;
        if (desc_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_after got=done%b busy%b want=done0 busy0", desc_done, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (start_cnt - s0 != 1) begin
            bad++;
            $display("FAIL single_starts got=%0d want=1", start_cnt - s0);
        end
        ok = 1'b1;
    endtask

    task automatic test_split();
        bit ok;
        logic [15:0] exp_len [3];
        exp_len[0] = 16'd4096;
        exp_len[1] = 16'd4096;
        exp_len[2] = 16'd1808;
        do_reset();
        push_desc(32'hC000_0000, 32'hC010_0000, 24'd10000);
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL split_start_timeout chunk=%0d got=none want=start", i);
            end
            total++;
            if (bus.cdma_src_addr !== 32'hC000_0000 + 32'(i) * 32'h1000 ||
                bus.cdma_dst_addr !== 32'hC010_0000 + 32'(i) * 32'h1000 ||
                bus.cdma_trans_len !== exp_len[i]) begin
                bad++;
                $display("FAIL split_chunk%0d got=%h/%h/%0d want=%h/%h/%0d", i,
                         bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len,
                         32'hC000_0000 + 32'(i) * 32'h1000, 32'hC010_0000 + 32'(i) * 32'h1000, exp_len[i]);
            end
            pulse_done(3);
            total++;
            if (desc_done !== (i == 2)) begin
                bad++;
                $display("FAIL split_desc_done chunk=%0d got=%b want=%b", i, desc_done, (i == 2));
            end
        end
    endtask

    task automatic test_4k_split();
        bit ok;
        int s0;
        do_reset();
        s0 = start_cnt;
        push_desc(32'hC000_0F00, 32'hC001_0000, 24'd512);
        wait_start(ok);
`ifdef CDMA_SCHED_4K_SPLIT_EN
        total++;
        if (!ok || bus.cdma_src_addr !== 32'hC000_0F00 || bus.cdma_trans_len !== 16'd256) begin
            bad++;
            $display("FAIL 4k_chunk0 got=%h/%0d want=c0000f00/256", bus.cdma_src_addr, bus.cdma_trans_len);
        end
        pulse_done(2);
        wait_start(ok);
        total++;
        if (!ok || bus.cdma_src_addr !== 32'hC000_1000 || bus.cdma_dst_addr !== 32'hC001_0100 ||
            bus.cdma_trans_len !== 16'd256) begin
            bad++;
            $display("FAIL 4k_chunk1 got=%h/%h/%0d want=c0001000/c0010100/256",
                     bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len);
        end
        pulse_done(2);
        repeat (2) @(negedge clk);
        total++;
        if (start_cnt - s0 != 2) begin
            bad++;
            $display("FAIL 4k_starts got=%0d want=2", start_cnt - s0);
        end
`else
        total++;
        if (!ok || bus.cdma_src_addr !== 32'hC000_0F00 || bus.cdma_trans_len !== 16'd512) begin
            bad++;
            $display("FAIL 4k_chunk0 got=%h/%0d want=c0000f00/512", bus.cdma_src_addr, bus.cdma_trans_len);
        end
        pulse_done(2);
        repeat (2) @(negedge clk);
        total++;
        if (start_cnt - s0 != 1) begin
            bad++;
            $display("FAIL 4k_starts got=%0d want=1", start_cnt - s0);
        end
`endif
    endtask

    task automatic test_backpressure();
        int acc;
        int n;
        do_reset();
        acc = 0;
        @(negedge clk);
        bus.req_src   = 32'hA000_0000;
        bus.req_dst   = 32'hB000_0000;
        bus.req_len   = 24'd64;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        total++;
        if (acc != 5) begin
            bad++;
            $display("FAIL bp_accepted got=%0d want=5", acc);
        end
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_low got=%b want=0", bus.req_ready);
        end
        pulse_done(2);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_rise got=%b want=1", bus.req_ready);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        int s0;
        int d0;
        do_reset();
        s0 = start_cnt;
        d0 = done_cnt;
        push_desc(32'hC000_2000, 32'hC000_3000, 24'd0);
        push_desc(32'hC000_4000, 32'hC000_5000, 24'd64);
        wait_start(ok);
        total++;
        if (!ok || bus.cdma_src_addr !== 32'hC000_4000 || bus.cdma_trans_len !== 16'd64) begin
            bad++;
            $display("FAIL zero_second_cmd got=%h/%0d want=c0004000/64", bus.cdma_src_addr, bus.cdma_trans_len);
        end
        @(negedge clk);
        total++;
        if (start_cnt - s0 != 1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL zero_counts got=starts%0d dones%0d want=starts1 dones1", start_cnt - s0, done_cnt - d0);
        end
        pulse_done(2);
        total++;
        if (desc_done !== 1'b1) begin
            bad++;
            $display("FAIL zero_second_done got=%b want=1", desc_done);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int s0;
        int d0;
        do_reset();
        push_desc(32'hC000_6000, 32'hC000_7000, 24'd128);
        wait_start(ok);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (bus.req_ready !== 1'b1 || bus.cdma_start !== 1'b0 || busy !== 1'b0 || desc_done !== 1'b0 ||
            bus.cdma_src_addr !== 32'h0 || bus.cdma_dst_addr !== 32'h0 || bus.cdma_trans_len !== 16'h0) begin
            bad++;
            $display("FAIL rw_reset_vals got=ready%b start%b busy%b done%b %h/%h/%0d want=ready1 start0 busy0 done0 0/0/0",
                     bus.req_ready, bus.cdma_start, busy, desc_done,
                     bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len);
        end
        s0 = start_cnt;
        d0 = done_cnt;
        pulse_done(4);
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt != d0 || start_cnt != s0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rw_late_done got=dones%0d starts%0d busy%b want=dones0 starts0 busy0",
                     done_cnt - d0, start_cnt - s0, busy);
        end
        push_desc(32'hC000_8000, 32'hC000_9000, 24'd64);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (bus.cdma_start !== (c == 4)) begin
                bad++;
                $display("FAIL rw_latency cycle=k+%0d got=%b want=%b", c, bus.cdma_start, (c == 4));
            end
            if (c < 4) @(negedge clk);
        end
        total++;
        if (bus.cdma_src_addr !== 32'hC000_8000 || bus.cdma_trans_len !== 16'd64) begin
            bad++;
            $display("FAIL rw_new_cmd got=%h/%0d want=c0008000/64", bus.cdma_src_addr, bus.cdma_trans_len);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.cdma_done = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_4k_split();
        test_backpressure();
        test_zero_len();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
